cmp_cast_arbiter: RTL

- Shared compare/boolean-cast unit arbitrated round-robin between N requesters.
- Each request carries two operands with individual valid widths and a signedness flag.
- The block casts both operands to a common W-bit type (mask, then zero- or sign-extend), then evaluates a relational or boolean-cast opcode.
- It is the runtime counterpart of the operand-width-unification and bool-cast rules, used by the evaluation engine for mixed-width comparisons.

---
 rtl/cmp_cast_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cmp_cast_arbiter.sv
// Shared compare / boolean-cast unit: round-robin arbitration between N requesters,
// a cast stage (mask, zero- or sign-extend to W bits) and a registered compare stage.
module cmp_cast_arbiter #(
    parameter int N   = 3,
    parameter int W   = 32,
    parameter int IDW = (N > 1) ? $clog2(N) : 1,
    parameter int WW  = $clog2(W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N*3-1:0]    req_op,
    input  logic [N-1:0]      req_signed,
    input  logic [N*W-1:0]    req_a,
    input  logic [N*WW-1:0]   req_wa,
    input  logic [N*W-1:0]    req_b,
    input  logic [N*WW-1:0]   req_wb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_result,
    output logic              rsp_err
);

    typedef enum logic [2:0] {
        OP_EQ   = 3'd0,
        OP_NE   = 3'd1,
        OP_LT   = 3'd2,
        OP_LE   = 3'd3,
        OP_GT   = 3'd4,
        OP_GE   = 3'd5,
        OP_LNOT = 3'd6,
        OP_BOOL = 3'd7
    } op_e;

    // Keep the low w bits of x; every bit above is filled with bit w-1 (signed) or 0.
    function automatic logic [W-1:0] cast_ext(input logic [W-1:0] x,
                                              input logic [WW-1:0] w,
                                              input logic sgn);
        logic [W-1:0] r;
        logic         fill;
        int           wi;
        wi   = int'(w);
        fill = 1'b0;
        r    = '0;
        for (int i = 0; i < W; i++) begin
            if (sgn && (i == wi - 1)) fill = x[i];
        end
        for (int i = 0; i < W; i++) begin
            r[i] = (i < wi) ? x[i] : fill;
        end
        return r;
    endfunction

    function automatic logic width_ok(input logic [WW-1:0] w);
        return (w != '0) && (w <= WW'(W));
    endfunction

    logic [IDW-1:0] rr_ptr;

    logic           s1_valid;
    logic [IDW-1:0] s1_id;
    op_e            s1_op;
    logic           s1_signed;
    logic [W-1:0]   s1_a;
    logic [W-1:0]   s1_b;
    logic           s1_err;

    logic           stall;
    logic           s1_free;
    logic           handshake;

    logic [N-1:0]   grant;
    logic [IDW-1:0] gnt_id;
    logic           gnt_any;

    op_e            sel_op;
    logic           sel_signed;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [WW-1:0]  sel_wa;
    logic [WW-1:0]  sel_wb;
    logic           sel_err;

    logic           cmp_res;
    logic           cmp_eq;
    logic           cmp_lt;
    logic           a_nz;

    assign stall     = rsp_valid & ~rsp_ready;
    assign s1_free   = ~s1_valid | ~stall;
    assign handshake = gnt_any & s1_free;
    assign req_ready = s1_free ? grant : '0;

    // Search starts one past the last granted requester.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grant   = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % N;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any     = 1'b1;
                grant[idx]  = 1'b1;
                gnt_id      = IDW'(idx);
            end
        end
    end

    always_comb begin
        sel_op     = op_e'(req_op[int'(gnt_id)*3 +: 3]);
        sel_signed = req_signed[gnt_id];
        sel_a      = req_a[int'(gnt_id)*W +: W];
        sel_b      = req_b[int'(gnt_id)*W +: W];
        sel_wa     = req_wa[int'(gnt_id)*WW +: WW];
        sel_wb     = req_wb[int'(gnt_id)*WW +: WW];
        // B is not looked at by the unary opcodes, so its width cannot flag an error there.
        sel_err    = !width_ok(sel_wa) ||
                     (!(sel_op inside {OP_LNOT, OP_BOOL}) && !width_ok(sel_wb));
    end

    always_comb begin
        cmp_eq  = (s1_a == s1_b);
        cmp_lt  = s1_signed ? ($signed(s1_a) < $signed(s1_b)) : (s1_a < s1_b);
        a_nz    = |s1_a;
        cmp_res = 1'b0;
        case (s1_op)
            OP_EQ:   cmp_res = cmp_eq;
            OP_NE:   cmp_res = !cmp_eq;
            OP_LT:   cmp_res = cmp_lt;
            OP_LE:   cmp_res = cmp_lt | cmp_eq;
            OP_GT:   cmp_res = !(cmp_lt | cmp_eq);
            OP_GE:   cmp_res = !cmp_lt;
            OP_LNOT: cmp_res = !a_nz;
            OP_BOOL: cmp_res = a_nz;
            default: cmp_res = 1'b0;
        endcase
        if (s1_err) cmp_res = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= IDW'(N - 1);
            s1_valid   <= 1'b0;
            s1_id      <= '0;
            s1_op      <= OP_EQ;
            s1_signed  <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_err     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let stage 1 and the output stage both read pre-edge values.
            if (handshake) begin
                s1_valid  <= 1'b1;
                s1_id     <= gnt_id;
                s1_op     <= sel_op;
                s1_signed <= sel_signed;
                s1_a      <= cast_ext(sel_a, sel_wa, sel_signed);
                s1_b      <= cast_ext(sel_b, sel_wb, sel_signed);
                s1_err    <= sel_err;
                rr_ptr    <= gnt_id;
            end else if (!stall) begin
                s1_valid  <= 1'b0;
            end

            if (!stall) begin
                rsp_valid <= s1_valid;
                if (s1_valid) begin
                    rsp_id     <= s1_id;
                    rsp_result <= cmp_res;
                    rsp_err    <= s1_err;
                end
            end
        end
    end

endmodule
